// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: branch/jump type encodings and reset defaults
// used by the ID-stage branch resolution and PC logic.
package mips_defs;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLEZ = 4'd2;
    localparam logic [3:0] BR_BGTZ = 4'd3;
    localparam logic [3:0] BR_BLTZ = 4'd4;
    localparam logic [3:0] BR_BGEZ = 4'd5;
    localparam logic [3:0] BR_J    = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JR   = 4'd8;
    localparam logic [3:0] BR_JALR = 4'd9;

endpackage

// File: rtl/branch_pc_unit_target_gen.sv
// Combinational branch condition decode and target address selection.
// Register jumps report a misaligned rs value but still produce the
// word-aligned target so fetch never issues an unaligned address.
module branch_target_gen
    import mips_defs::*;
(
    input  logic [3:0]         br_type,
    input  logic               greater,
    input  logic               equal,
    input  logic               less,
    input  logic [INSTR_W-1:0] id_pc,
    input  logic [15:0]        imm16,
    input  logic [25:0]        instr_index,
    input  logic [INSTR_W-1:0] rs_data,
    output logic               cond,
    output logic [INSTR_W-1:0] target,
    output logic               misalign
);

    logic [INSTR_W-1:0] id_pc_plus4;
    logic [INSTR_W-1:0] br_offset;

    assign id_pc_plus4 = id_pc + 32'd4;
    assign br_offset   = {{14{imm16[15]}}, imm16, 2'b00};

    // Decode the branch condition; equal wins when the flags are not one-hot
    always_comb begin
        cond     = 1'b0;
        target   = id_pc_plus4 + br_offset;
        misalign = 1'b0;
        case (br_type)
            BR_BEQ:  cond = equal;
            BR_BNE:  cond = ~equal;
            BR_BLEZ: cond = equal ? 1'b1 : less;
            BR_BGTZ: cond = equal ? 1'b0 : greater;
            BR_BLTZ: cond = equal ? 1'b0 : less;
            BR_BGEZ: cond = equal ? 1'b1 : greater;
            BR_J, BR_JAL: begin
                cond   = 1'b1;
                target = {id_pc_plus4[31:28], instr_index, 2'b00};
            end
            BR_JR, BR_JALR: begin
                cond     = 1'b1;
                target   = {rs_data[31:2], 2'b00};
                misalign = (rs_data[1:0] != 2'b00);
            end
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// ID-stage branch resolution and PC register owner. A taken branch is
// resolved while its delay slot is being fetched; the redirect is applied
// on the next accepted fetch, parked in target_q if imem is not ready.
module branch_pc_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [3:0]        br_type,
    input  logic              greater,
    input  logic              equal,
    input  logic              less,
    input  logic [31:0]       id_pc,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [31:0]       rs_data,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [31:0]       pc,
    output logic              taken,
    output logic [31:0]       link_addr,
    output logic              addr_err,
    output logic              bds_err,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [0:0] SEQ  = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]  state;
    logic [31:0] target_q;
    logic        running;
    logic        cond;
    logic        misalign;
    logic [31:0] target;
    logic        accept;
    logic        br_live;
    logic        is_reg_jump;

    branch_target_gen u_target_gen (
        .br_type     (br_type),
        .greater     (greater),
        .equal       (equal),
        .less        (less),
        .id_pc       (id_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .cond        (cond),
        .target      (target),
        .misalign    (misalign)
    );

    assign imem_req    = running & ~stall;
    assign accept      = imem_req & imem_ready;
    assign br_live     = br_valid & ~stall;
    assign taken       = br_live & (state == SEQ) & cond;
    assign link_addr   = id_pc + 32'd8;
    assign is_reg_jump = (br_type == BR_JR) || (br_type == BR_JALR);

    // Fetch is held off until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= 1'b1;
    end

    // PC register and redirect FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= SEQ;
            target_q <= 32'd0;
        end else if (state == SEQ) begin
            if (taken && accept) begin
                pc <= target;
            end else if (taken) begin
                target_q <= target;
                state    <= PEND;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end else if (accept) begin
            pc    <= target_q;
            state <= SEQ;
        end
    end

    // Misaligned register-jump pulse and sticky delay-slot violation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
            bds_err  <= 1'b0;
        end else begin
            addr_err <= taken & is_reg_jump & misalign;
            if (br_live && state == PEND) bds_err <= 1'b1;
        end
    end

    // Performance counters for accepted and taken branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (br_live && state == SEQ) begin
            br_cnt <= br_cnt + CNT_W'(1);
            if (cond) taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: table of single-cycle branch vectors
// plus hand sequences for reset, pending redirect, stall and reset-in-PEND.
module tb_branch_pc_unit;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic [3:0]  br_type;
    logic        greater, equal, less;
    logic [31:0] id_pc;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] link_addr;
    logic        addr_err;
    logic        bds_err;
    logic [15:0] br_cnt;
    logic [15:0] taken_cnt;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_pc;

    typedef struct {
        logic        valid;
        logic [3:0]  typ;
        logic [2:0]  flags;   // {greater, equal, less}
        logic [31:0] ipc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_link;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    branch_pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .greater     (greater),
        .equal       (equal),
        .less        (less),
        .id_pc       (id_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc          (pc),
        .taken       (taken),
        .link_addr   (link_addr),
        .addr_err    (addr_err),
        .bds_err     (bds_err),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        br_valid    = v.valid;
        br_type     = v.typ;
        {greater, equal, less} = v.flags;
        id_pc       = v.ipc;
        imm16       = v.imm;
        instr_index = v.idx;
        rs_data     = v.rs;
    endtask

    initial begin
        vecs[0]  = '{1'b1, BR_BEQ,  3'b010, 32'h0000_3000, 16'h0004, 26'd0, 32'd0, 1'b1, 32'h0000_3014, 32'h0000_3008};
        vecs[1]  = '{1'b1, BR_BNE,  3'b010, 32'h0000_3010, 16'h0004, 26'd0, 32'd0, 1'b0, 32'h0,         32'h0000_3018};
        vecs[2]  = '{1'b1, BR_BLTZ, 3'b001, 32'h0000_3010, 16'hFFFF, 26'd0, 32'd0, 1'b1, 32'h0000_3010, 32'h0000_3018};
        vecs[3]  = '{1'b1, BR_BLEZ, 3'b100, 32'h0000_3010, 16'h0004, 26'd0, 32'd0, 1'b0, 32'h0,         32'h0000_3018};
        vecs[4]  = '{1'b1, BR_BGTZ, 3'b100, 32'h0000_3100, 16'h0010, 26'd0, 32'd0, 1'b1, 32'h0000_3144, 32'h0000_3108};
        vecs[5]  = '{1'b1, BR_BGEZ, 3'b010, 32'h0000_3144, 16'h8000, 26'd0, 32'd0, 1'b1, 32'hFFFE_3148, 32'h0000_314C};
        vecs[6]  = '{1'b1, BR_J,    3'b000, 32'h1000_0010, 16'h0000, 26'h0ABCDEF, 32'd0, 1'b1, 32'h12AF_37BC, 32'h1000_0018};
        vecs[7]  = '{1'b1, BR_JAL,  3'b000, 32'hF000_0FFC, 16'h0000, 26'h3FFFFFF, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'hF000_1004};
        vecs[8]  = '{1'b1, BR_JR,   3'b000, 32'h0000_3000, 16'h0000, 26'd0, 32'h0000_5008, 1'b1, 32'h0000_5008, 32'h0000_3008};
        vecs[9]  = '{1'b1, BR_JALR, 3'b000, 32'h0000_3000, 16'h0000, 26'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h0000_3008};
        vecs[10] = '{1'b0, BR_BEQ,  3'b010, 32'h0000_3000, 16'h0004, 26'd0, 32'd0, 1'b0, 32'h0,         32'h0000_3008};
        vecs[11] = '{1'b1, BR_BEQ,  3'b100, 32'h0000_3000, 16'h0004, 26'd0, 32'd0, 1'b0, 32'h0,         32'h0000_3008};
        vecs[12] = '{1'b1, BR_BNE,  3'b001, 32'h0000_3000, 16'h0002, 26'd0, 32'd0, 1'b1, 32'h0000_300C, 32'h0000_3008};
        vecs[13] = '{1'b1, BR_BLEZ, 3'b010, 32'h0000_2000, 16'h0000, 26'd0, 32'd0, 1'b1, 32'h0000_2004, 32'h0000_2008};
        vecs[14] = '{1'b1, BR_BEQ,  3'b010, 32'hFFFF_FFF8, 16'h0001, 26'd0, 32'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[15] = '{1'b1, BR_BLEZ, 3'b110, 32'h0000_3000, 16'h0000, 26'd0, 32'd0, 1'b1, 32'h0000_3004, 32'h0000_3008};

        // Reset and fetch start
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        applyStimulus('{1'b0, BR_BEQ, 3'b000, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0, 32'd0, 32'd0});
        #12;
        checkOutput("reset_pc", pc, 32'h0000_3000);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset_cnt", {16'd0, br_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_pc", pc, 32'h0000_3000);
        exp_pc = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp_pc = exp_pc + 32'd4;
            checkOutput("seq_pc", pc, exp_pc);
        end

        // Single-cycle branch vectors, imem always ready
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("taken_%0d", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            checkOutput($sformatf("link_%0d", i), link_addr, vecs[i].exp_link);
            @(posedge clk); #1;
            exp_pc = vecs[i].exp_taken ? vecs[i].exp_target : exp_pc + 32'd4;
            checkOutput($sformatf("pc_%0d", i), pc, exp_pc);
            checkOutput($sformatf("aerr_%0d", i), {31'd0, addr_err}, 32'd0);
        end
        checkOutput("br_cnt_tbl", {16'd0, br_cnt}, 32'd15);
        checkOutput("taken_cnt_tbl", {16'd0, taken_cnt}, 32'd12);

        // Misaligned JR with imem stalled, branch in delay slot while pending
        @(negedge clk);
        applyStimulus('{1'b1, BR_JR, 3'b000, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_4001, 1'b0, 32'd0, 32'd0});
        imem_ready = 1'b0;
        #1 checkOutput("jr_taken", {31'd0, taken}, 32'd1);
        @(negedge clk);
        applyStimulus('{1'b1, BR_BEQ, 3'b010, 32'h0000_3004, 16'h0004, 26'd0, 32'd0, 1'b0, 32'd0, 32'd0});
        #1;
        checkOutput("jr_aerr_pulse", {31'd0, addr_err}, 32'd1);
        checkOutput("pend_taken", {31'd0, taken}, 32'd0);
        @(posedge clk); #1;
        checkOutput("pend_hold_pc", pc, exp_pc);
        checkOutput("bds_err_set", {31'd0, bds_err}, 32'd1);
        checkOutput("aerr_clear", {31'd0, addr_err}, 32'd0);
        @(negedge clk); br_valid = 1'b0; imem_ready = 1'b1;
        @(posedge clk); #1;
        exp_pc = 32'h0000_4000;
        checkOutput("jr_pc", pc, exp_pc);
        checkOutput("br_cnt_jr", {16'd0, br_cnt}, 32'd16);
        checkOutput("taken_cnt_jr", {16'd0, taken_cnt}, 32'd13);

        // Stall freezes everything
        @(negedge clk);
        applyStimulus('{1'b1, BR_BEQ, 3'b010, 32'h0000_4000, 16'h0004, 26'd0, 32'd0, 1'b0, 32'd0, 32'd0});
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
            checkOutput("stall_taken", {31'd0, taken}, 32'd0);
            @(posedge clk); #1;
            checkOutput("stall_pc", pc, exp_pc);
            @(negedge clk);
        end
        stall = 1'b0; br_valid = 1'b0;
        checkOutput("stall_br_cnt", {16'd0, br_cnt}, 32'd16);
        checkOutput("bds_sticky", {31'd0, bds_err}, 32'd1);

        // Reset while a redirect is pending
        applyStimulus('{1'b1, BR_J, 3'b000, 32'h0000_4000, 16'd0, 26'h0000100, 32'd0, 1'b0, 32'd0, 32'd0});
        imem_ready = 1'b0;
        @(posedge clk); #2;
        br_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pend_pc", pc, 32'h0000_3000);
        checkOutput("rst_pend_bds", {31'd0, bds_err}, 32'd0);
        checkOutput("rst_pend_cnt", {16'd0, br_cnt}, 32'd0);
        checkOutput("rst_pend_tcnt", {16'd0, taken_cnt}, 32'd0);
        checkOutput("rst_pend_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("restart_pc0", pc, 32'h0000_3000);
        @(posedge clk); #1;
        checkOutput("restart_pc1", pc, 32'h0000_3004);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
